// File: rtl/usb_serial_pkg.sv
// usb_serial_pkg
// Shared definitions for the USB serial-function IN endpoint sequencer:
// the endpoint FSM state type and the default buffer/flush parameters.
// Optional feature macro used by the importing top: USB_SERIAL_IN_ZLP_EN.
package usb_serial_pkg;

  typedef enum logic {
    StFill  = 1'b0,
    StReady = 1'b1
  } in_state_e;

  localparam int MaxPktSizeByteDef = 32;
  localparam int FlushCyclesDef    = 256;

endpackage

// File: rtl/usb_serial_pkt_buf.sv
// usb_serial_pkt_buf
// Single-packet byte store for the bulk IN endpoint.
// One synchronous write port, one asynchronous read port. Contents are
// deliberately not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write byte
//   raddr_i  read address
//   rdata_o  byte at raddr_i (combinational)
module usb_serial_pkt_buf #(
  parameter int Depth = 32,
  parameter int AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_serial_in_pkt_ctrl.sv
// usb_serial_in_pkt_ctrl
// Sequencer for the serial-function bulk IN endpoint. Drains the TX byte
// stream into a one-packet buffer, releases the buffer as a packet when it
// is full or after a flush timeout, and hands it to the IN packet engine
// until ACKed (rollback keeps it for retransmission).
// Optional feature macro: USB_SERIAL_IN_ZLP_EN -- when defined, an idle
// period after an ACKed full-size packet sends a zero-length packet.
//
// state   | meaning
// StFill  | accepting TX bytes into the buffer
// StReady | packet (possibly ZLP) presented to the packet engine
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   enable_i                     endpoint configured; low flushes and idles
//   halt_i                       halt request, mirrored on in_ep_stall_o
//   tx_valid_i/tx_data_i/tx_ready_o  TX byte stream handshake
//   in_ep_rollback_i             retransmit current packet
//   in_ep_acked_i                host ACKed current packet
//   in_ep_get_addr_i             read address from packet engine
//   in_ep_data_get_i             read strobe (no state effect)
//   in_ep_stall_o                respond STALL
//   in_ep_has_data_o             packet ready
//   in_ep_data_o                 buffer byte at in_ep_get_addr_i
//   in_ep_data_done_o            current address is the last byte (or ZLP)
module usb_serial_in_pkt_ctrl
  import usb_serial_pkg::*;
#(
  parameter int MaxPktSizeByte = MaxPktSizeByteDef,
  parameter int PktW           = $clog2(MaxPktSizeByte),
  parameter int FlushCycles    = FlushCyclesDef
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            halt_i,
  input  logic            tx_valid_i,
  input  logic [7:0]      tx_data_i,
  output logic            tx_ready_o,
  input  logic            in_ep_rollback_i,
  input  logic            in_ep_acked_i,
  input  logic [PktW-1:0] in_ep_get_addr_i,
  input  logic            in_ep_data_get_i,
  output logic            in_ep_stall_o,
  output logic            in_ep_has_data_o,
  output logic [7:0]      in_ep_data_o,
  output logic            in_ep_data_done_o
);

  localparam int CntW = $clog2(FlushCycles + 1);
  localparam logic [PktW:0]   MaxPtr   = (PktW + 1)'(MaxPktSizeByte);
  localparam logic [CntW-1:0] IdleLast = CntW'(FlushCycles - 1);

  in_state_e       state_q, state_d;
  logic [PktW:0]   wr_ptr_q, wr_ptr_d;
  logic [PktW:0]   pkt_len_q, pkt_len_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            zlp_pend_q, zlp_pend_d;
  logic            stall_q;
  logic            accept;
  logic [PktW:0]   rd_next;

  // Read strobe is informational only; the packet engine owns addressing.
  logic unused_data_get;
  assign unused_data_get = in_ep_data_get_i;

  assign tx_ready_o = enable_i & (state_q == StFill) & (wr_ptr_q < MaxPtr);
  assign accept     = tx_valid_i & tx_ready_o;

  usb_serial_pkt_buf #(
    .Depth (MaxPktSizeByte),
    .AddrW (PktW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[PktW-1:0]),
    .wdata_i (tx_data_i),
    .raddr_i (in_ep_get_addr_i),
    .rdata_o (in_ep_data_o)
  );

  assign rd_next           = {1'b0, in_ep_get_addr_i} + 1'b1;
  assign in_ep_has_data_o  = (state_q == StReady);
  assign in_ep_data_done_o = (state_q == StReady) &
                             ((pkt_len_q == '0) | (rd_next >= pkt_len_q));
  assign in_ep_stall_o     = stall_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pkt_len_d  = pkt_len_q;
    idle_cnt_d = idle_cnt_q;
    zlp_pend_d = zlp_pend_q;

    if (!enable_i) begin
      state_d    = StFill;
      wr_ptr_d   = '0;
      pkt_len_d  = '0;
      idle_cnt_d = '0;
      zlp_pend_d = 1'b0;
    end else begin
      case (state_q)
        StFill: begin
          if (accept) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            idle_cnt_d = '0;
            zlp_pend_d = 1'b0;
          end else if (wr_ptr_q == MaxPtr) begin
            state_d    = StReady;
            pkt_len_d  = wr_ptr_q;
            idle_cnt_d = '0;
          end else if ((wr_ptr_q != '0) || zlp_pend_q) begin
            // With an empty buffer this only fires for a pending ZLP, and
            // wr_ptr_q==0 then yields pkt_len 0.
            if (idle_cnt_q == IdleLast) begin
              state_d    = StReady;
              pkt_len_d  = wr_ptr_q;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
        end
        StReady: begin
          // ACK beats a simultaneous rollback; rollback alone keeps the packet.
          if (in_ep_acked_i) begin
            state_d    = StFill;
            wr_ptr_d   = '0;
            idle_cnt_d = '0;
`ifdef USB_SERIAL_IN_ZLP_EN
            zlp_pend_d = (pkt_len_q == MaxPtr);
`else
            zlp_pend_d = 1'b0;
`endif
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StFill;
      wr_ptr_q   <= '0;
      pkt_len_q  <= '0;
      idle_cnt_q <= '0;
      zlp_pend_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pkt_len_q  <= pkt_len_d;
      idle_cnt_q <= idle_cnt_d;
      zlp_pend_q <= zlp_pend_d;
      stall_q    <= halt_i;
    end
  end

endmodule

// File: tb/tb_usb_serial_in_pkt_ctrl.sv
// tb_usb_serial_in_pkt_ctrl
// Directed bench for usb_serial_in_pkt_ctrl. Expected values are hand-derived
// from the endpoint behaviour; ZLP expectations follow USB_SERIAL_IN_ZLP_EN.
module tb_usb_serial_in_pkt_ctrl;

  localparam int Mps  = 32;
  localparam int PktW = 5;
  localparam int Fc   = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            halt;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic            rollback;
  logic            acked;
  logic [PktW-1:0] addr;
  logic            data_get;
  logic            stall;
  logic            has_data;
  logic [7:0]      rdata;
  logic            done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_serial_in_pkt_ctrl #(
    .MaxPktSizeByte (Mps),
    .PktW           (PktW),
    .FlushCycles    (Fc)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .halt_i            (halt),
    .tx_valid_i        (tx_valid),
    .tx_data_i         (tx_data),
    .tx_ready_o        (tx_ready),
    .in_ep_rollback_i  (rollback),
    .in_ep_acked_i     (acked),
    .in_ep_get_addr_i  (addr),
    .in_ep_data_get_i  (data_get),
    .in_ep_stall_o     (stall),
    .in_ep_has_data_o  (has_data),
    .in_ep_data_o      (rdata),
    .in_ep_data_done_o (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    acked = 1'b1;
    tick();
    acked = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; halt = 1'b0; tx_valid = 1'b0; tx_data = '0;
    rollback = 1'b0; acked = 1'b0; addr = '0; data_get = 1'b0;
    repeat (3) tick();
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL reset_has_data got=%b exp=0", has_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    repeat (Fc - 1) @(posedge clk);
    #1;
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL flush_early got=%b exp=0", has_data); end
    tick();
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL flush_has_data got=%b exp=1", has_data); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL flush_tx_ready got=%b exp=0", tx_ready); end
    addr = 5'd4; #1;
    checks++; if (rdata !== 8'h15) begin errors++; $display("FAIL flush_a4_data got=%h exp=15", rdata); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush_a4_done got=%b exp=1", done); end
    addr = 5'd3; #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_a3_done got=%b exp=0", done); end
    checks++; if (rdata !== 8'h14) begin errors++; $display("FAIL flush_a3_data got=%h exp=14", rdata); end
    addr = 5'd0; #1;
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL flush_a0_data got=%h exp=11", rdata); end
    pulse_ack();
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL flush_ack got=%b exp=0", has_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL flush_ack_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_stream();
    tx_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tx_data = 8'(i + 1);
      if (i == 0 || i == 31) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b exp=1", i, tx_ready); end
      end
      tick();
    end
    tx_data = 8'd33;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL stream_full_ready got=%b exp=0", tx_ready); end
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL stream_full_hd got=%b exp=0", has_data); end
    tick();
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL stream_hd got=%b exp=1", has_data); end
    addr = 5'd31; #1;
    checks++; if (rdata !== 8'd32 || done !== 1'b1) begin errors++; $display("FAIL stream_a31 got=%h/%b exp=20/1", rdata, done); end
    pulse_ack();
    for (int j = 33; j <= 40; j++) begin
      tx_data = 8'(j);
      tick();
    end
    tx_valid = 1'b0;
    repeat (Fc - 1) @(posedge clk);
    #1;
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL stream2_early got=%b exp=0", has_data); end
    tick();
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL stream2_hd got=%b exp=1", has_data); end
    addr = 5'd7; #1;
    checks++; if (rdata !== 8'd40 || done !== 1'b1) begin errors++; $display("FAIL stream2_a7 got=%h/%b exp=28/1", rdata, done); end
    addr = 5'd6; #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream2_a6_done got=%b exp=0", done); end
    addr = 5'd0; #1;
    checks++; if (rdata !== 8'd33) begin errors++; $display("FAIL stream2_a0 got=%h exp=21", rdata); end
    pulse_ack();
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL stream2_ack got=%b exp=0", has_data); end
  endtask

  task automatic test_rollback();
    for (int i = 0; i < 32; i++) push(8'(8'hA0 + i));
    tick();
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL rb_hd got=%b exp=1", has_data); end
    for (int r = 0; r < 2; r++) begin
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL rb%0d_hd got=%b exp=1", r, has_data); end
      addr = 5'd5; #1;
      checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rb%0d_a5 got=%h exp=a5", r, rdata); end
      addr = 5'd31; #1;
      checks++; if (rdata !== 8'hBF || done !== 1'b1) begin errors++; $display("FAIL rb%0d_a31 got=%h/%b exp=bf/1", r, rdata, done); end
    end
    pulse_ack();
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL rb_ack got=%b exp=0", has_data); end
  endtask

  task automatic test_zlp();
    for (int i = 0; i < 32; i++) push(8'(8'h40 + i));
    tick();
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL zlp_full_hd got=%b exp=1", has_data); end
    pulse_ack();
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL zlp_ack_hd got=%b exp=0", has_data); end
    repeat (Fc - 1) @(posedge clk);
    #1;
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL zlp_early got=%b exp=0", has_data); end
    tick();
    addr = 5'd0; #1;
`ifdef USB_SERIAL_IN_ZLP_EN
    checks++; if (has_data !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL zlp_ready got=%b/%b exp=1/1", has_data, done); end
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    checks++; if (has_data !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL zlp_rb got=%b/%b exp=1/1", has_data, done); end
    pulse_ack();
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL zlp_ack2 got=%b exp=0", has_data); end
`else
    checks++; if (has_data !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL nozlp got=%b/%b exp=0/0", has_data, done); end
`endif
    repeat (Fc + 4) @(posedge clk);
    #1;
    checks++; if (has_data !== 1'b0) begin errors++; $display("FAIL zlp_idle got=%b exp=0", has_data); end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 10; i++) push(8'(8'h60 + i));
    repeat (Fc) @(posedge clk);
    #1;
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL en_hd got=%b exp=1", has_data); end
    enable = 1'b0;
    tick();
    addr = 5'd0; #1;
    checks++; if (has_data !== 1'b0 || tx_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL en_off got=%b/%b/%b exp=0/0/0", has_data, tx_ready, done); end
    tick();
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL en_off_ready got=%b exp=0", tx_ready); end
    enable = 1'b1; #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL en_on_ready got=%b exp=1", tx_ready); end
    push(8'h77);
    repeat (Fc) @(posedge clk);
    #1;
    addr = 5'd0; #1;
    checks++; if (has_data !== 1'b1 || rdata !== 8'h77 || done !== 1'b1) begin errors++; $display("FAIL en_restart got=%b/%h/%b exp=1/77/1", has_data, rdata, done); end
    pulse_ack();
  endtask

  task automatic test_halt_ack_rb();
    halt = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_pre got=%b exp=0", stall); end
    tick();
    halt = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_clr got=%b exp=0", stall); end
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    repeat (Fc) @(posedge clk);
    #1;
    checks++; if (has_data !== 1'b1) begin errors++; $display("FAIL both_pre got=%b exp=1", has_data); end
    acked = 1'b1; rollback = 1'b1;
    tick();
    acked = 1'b0; rollback = 1'b0;
    checks++; if (has_data !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL both_ack got=%b/%b exp=0/1", has_data, tx_ready); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_flush();
    test_stream();
    test_rollback();
    test_zlp();
    test_enable();
    test_halt_ack_rb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
